decode_control_stage: RTL and testbench
=======================================

Name: decode_control_stage

Overview:
- Next-generation decode-stage control for the pipelined MIPS core.
- Decodes the full supported opcode/funct set into a control word and registers it into the ID/EX boundary.
- Detects load-use hazards and inserts bubbles; honours branch/jump flushes.
- Runs a HALT drain state machine that freezes fetch until the pipeline empties.

Parameters:
- NB_OP, 6, opcode and funct width.
- NB_REG, 5, register-specifier width.
- NB_EXT, 2, extension-mode width.
- DRAIN_CYCLES, 4, cycles after HALT leaves ID until the pipeline is empty; must be ≥1.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous, active-high reset.
- i_enable  in  1  step enable from the debug unit; 0 holds all state.
- i_valid  in  1  IF/ID holds a real instruction.
- i_opcode  in  NB_OP  instruction[31:26].
- i_funct  in  NB_OP  instruction[5:0].
- i_rs  in  NB_REG  instruction[25:21].
- i_rt  in  NB_REG  instruction[20:16].
- i_ex_mem_read  in  1  ID/EX instruction is a load.
- i_ex_rt  in  NB_REG  ID/EX destination rt.
- i_flush  in  1  taken branch/jump resolved downstream; squash ID.
- o_stall  out  1  hold PC and IF/ID (combinational).
- o_valid  out  1  registered: ID/EX holds a real instruction.
- o_alu_src  out  1  registered: ALU B operand is the immediate.
- o_ext_mode  out  NB_EXT  registered: 00 sign-extend, 01 zero-extend, 10 LUI (imm<<16).
- o_alu_op  out  2  registered: 00 add, 01 sub/compare, 10 R-type funct, 11 immediate logic.
- o_reg_dst  out  1  registered: 1 selects rd, 0 selects rt.
- o_reg_write  out  1  registered.
- o_mem_read  out  1  registered.
- o_mem_write  out  1  registered.
- o_mem_to_reg  out  1  registered.
- o_branch  out  1  registered: BEQ.
- o_branch_ne  out  1  registered: BNE.
- o_jump  out  1  registered: J/JAL.
- o_link  out  1  registered: JAL writes r31.
- o_halted  out  1  registered: core is halted.

Behaviour:
- Decode (combinational):
  - R-type 000000: reg_dst=1, reg_write=1, alu_op=10.
  - ADDI 001000: alu_src=1, ext=00, alu_op=00, reg_write=1.
  - SLTI 001010: alu_src=1, ext=00, alu_op=01, reg_write=1.
  - ANDI 001100, ORI 001101, XORI 001110: alu_src=1, ext=01, alu_op=11, reg_write=1.
  - LUI 001111: alu_src=1, ext=10, alu_op=00, reg_write=1.
  - LW 100011: alu_src=1, ext=00, mem_read=1, mem_to_reg=1, reg_write=1.
  - SW 101011: alu_src=1, ext=00, mem_write=1.
  - BEQ 000100: branch=1, ext=00, alu_op=01.
  - BNE 000101: branch_ne=1, ext=00, alu_op=01.
  - J 000010: jump=1.
  - JAL 000011: jump=1, link=1, reg_write=1.
  - HALT 111111: no side-effect controls.
  - Unknown opcode, or R-type with funct=000000 and rs=0 (NOP): all-zero word.
- Hazard detection:
  - uses_rt = R-type | SW | BEQ | BNE.
  - hazard = i_valid & i_ex_mem_read & (i_ex_rt≠0) & ((i_ex_rt==i_rs) | (uses_rt & i_ex_rt==i_rt)).
- FSM states: RUN, DRAIN, HALTED. Down-counter cnt has width $clog2(DRAIN_CYCLES+1).
  - RUN → DRAIN: i_valid & HALT & ~hazard & ~i_flush; cnt ← DRAIN_CYCLES-1.
  - DRAIN: cnt decrements each enabled cycle; at cnt==0 → HALTED.
  - DRAIN with i_flush → RUN (HALT was on the wrong path); cnt cleared.
  - HALTED is left only by reset; i_flush is ignored in HALTED.
- o_stall = (RUN & hazard & ~i_flush) | DRAIN | HALTED.
- Register update (only when i_enable=1), in priority order:
  1. reset: all outputs 0, state RUN, cnt 0.
  2. i_flush: bubble (all control 0, o_valid 0).
  3. state≠RUN, or a HALT instruction: bubble.
  4. hazard: bubble; IF/ID is held by o_stall, so the instruction re-decodes next cycle.
  5. otherwise: decoded word, with o_valid=i_valid; i_valid=0 yields a bubble.
- i_enable=0: every register and the FSM hold; o_stall stays live.
- Latency: one cycle from the ID fields to the ID/EX outputs.
- o_halted=1 exactly in HALTED; it rises DRAIN_CYCLES enabled cycles after the HALT-decode edge.
- Simultaneous hazard and flush: flush wins; o_stall=0 so fetch redirects.

Decomposition:
- Shared package mips_ctrl_pkg:
  - opcode/funct localparams.
  - EXT_SIGN/EXT_ZERO/EXT_LUI.
  - ALUOP_* encodings.
  - State encodings.
  - Packed control-word field order.
- Sub-module: control_decoder, the pure combinational opcode/funct→control-word decode.
- The top level holds the hazard logic, FSM, counter and ID/EX register.

Test Plan:
- ADDI then ANDI, no hazard → next cycle: alu_src=1, ext=00; then ext=01; o_valid=1; o_stall=0 throughout.
- LW r5 in EX (i_ex_mem_read=1, i_ex_rt=5), ADD rs=5 in ID → o_stall=1; next outputs bubble with o_valid=0; hazard cleared next cycle → ADD word registered.
- Same as above but i_ex_rt=0 → o_stall=0, no bubble. ADDI with rt=5 and rs≠5 → no stall.
- Hazard and i_flush together → o_stall=0; bubble registered.
- HALT with DRAIN_CYCLES=4 → o_stall=1 from the next cycle; o_halted=1 four enabled cycles later. Inserting i_enable=0 cycles stretches this exactly by their count.
- HALT, then i_flush on the second DRAIN cycle → state RUN, o_stall=0, o_halted never asserts. Reset while HALTED → all outputs 0, state RUN.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS decode-stage control: opcodes, control-word
// layout, ALU/extension selects and the HALT drain FSM states.
package mips_ctrl_pkg;

    localparam int NB_OP  = 6;
    localparam int NB_REG = 5;
    localparam int NB_EXT = 2;

    localparam logic [NB_OP-1:0] OP_RTYPE = 6'b000000;
    localparam logic [NB_OP-1:0] OP_J     = 6'b000010;
    localparam logic [NB_OP-1:0] OP_JAL   = 6'b000011;
    localparam logic [NB_OP-1:0] OP_BEQ   = 6'b000100;
    localparam logic [NB_OP-1:0] OP_BNE   = 6'b000101;
    localparam logic [NB_OP-1:0] OP_ADDI  = 6'b001000;
    localparam logic [NB_OP-1:0] OP_SLTI  = 6'b001010;
    localparam logic [NB_OP-1:0] OP_ANDI  = 6'b001100;
    localparam logic [NB_OP-1:0] OP_ORI   = 6'b001101;
    localparam logic [NB_OP-1:0] OP_XORI  = 6'b001110;
    localparam logic [NB_OP-1:0] OP_LUI   = 6'b001111;
    localparam logic [NB_OP-1:0] OP_LW    = 6'b100011;
    localparam logic [NB_OP-1:0] OP_SW    = 6'b101011;
    localparam logic [NB_OP-1:0] OP_HALT  = 6'b111111;

    localparam logic [NB_OP-1:0] FUNCT_NOP = 6'b000000;

    localparam logic [NB_EXT-1:0] EXT_SIGN = 2'b00;
    localparam logic [NB_EXT-1:0] EXT_ZERO = 2'b01;
    localparam logic [NB_EXT-1:0] EXT_LUI  = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } drain_state_t;

    // Field order, MSB first, matches the ID/EX register layout.
    typedef struct packed {
        logic              alu_src;
        logic [NB_EXT-1:0] ext_mode;
        logic [1:0]        alu_op;
        logic              reg_dst;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              branch;
        logic              branch_ne;
        logic              jump;
        logic              link;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/control_decoder.sv
// Pure combinational opcode/funct to control-word decode for the ID stage.
module control_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [NB_OP-1:0]  opcode,
    input  logic [NB_OP-1:0]  funct,
    input  logic [NB_REG-1:0] rs,
    output ctrl_word_t        ctrl
);

    always_comb begin
        ctrl = CTRL_BUBBLE;
        case (opcode)
            OP_RTYPE: begin
                // funct=0 with rs=0 is the canonical NOP and stays a zero word.
                if (!(funct == FUNCT_NOP && rs == '0)) begin
                    ctrl.reg_dst   = 1'b1;
                    ctrl.reg_write = 1'b1;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
            end
            OP_ADDI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.ext_mode  = EXT_SIGN;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.reg_write = 1'b1;
            end
            OP_SLTI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.ext_mode  = EXT_SIGN;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.reg_write = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.ext_mode  = EXT_ZERO;
                ctrl.alu_op    = ALUOP_IMM;
                ctrl.reg_write = 1'b1;
            end
            OP_LUI: begin
                ctrl.alu_src   = 1'b1;
                ctrl.ext_mode  = EXT_LUI;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.reg_write = 1'b1;
            end
            OP_LW: begin
                ctrl.alu_src    = 1'b1;
                ctrl.ext_mode   = EXT_SIGN;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.ext_mode  = EXT_SIGN;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl.branch   = 1'b1;
                ctrl.ext_mode = EXT_SIGN;
                ctrl.alu_op   = ALUOP_SUB;
            end
            OP_BNE: begin
                ctrl.branch_ne = 1'b1;
                ctrl.ext_mode  = EXT_SIGN;
                ctrl.alu_op    = ALUOP_SUB;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            OP_JAL: begin
                ctrl.jump      = 1'b1;
                ctrl.link      = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            default: ctrl = CTRL_BUBBLE;
        endcase
    end

endmodule

// File: rtl/decode_control_stage.sv
// Decode-stage control: load-use hazard bubbles, flush squash, HALT drain FSM
// and the ID/EX control register. o_state exposes the drain FSM state.
module decode_control_stage
    import mips_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic              i_valid,
    input  logic [NB_OP-1:0]  i_opcode,
    input  logic [NB_OP-1:0]  i_funct,
    input  logic [NB_REG-1:0] i_rs,
    input  logic [NB_REG-1:0] i_rt,
    input  logic              i_ex_mem_read,
    input  logic [NB_REG-1:0] i_ex_rt,
    input  logic              i_flush,
    output logic              o_stall,
    output logic              o_valid,
    output logic              o_alu_src,
    output logic [NB_EXT-1:0] o_ext_mode,
    output logic [1:0]        o_alu_op,
    output logic              o_reg_dst,
    output logic              o_reg_write,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic              o_mem_to_reg,
    output logic              o_branch,
    output logic              o_branch_ne,
    output logic              o_jump,
    output logic              o_link,
    output logic              o_halted,
    output logic [1:0]        o_state
);

    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

    ctrl_word_t   dec_ctrl;
    ctrl_word_t   id_ex_q;
    logic         valid_q;
    logic         halted_q;
    drain_state_t state_q;
    logic [CNT_W-1:0] cnt_q;

    logic uses_rt;
    logic is_halt;
    logic hazard;

    control_decoder u_decoder (
        .opcode (i_opcode),
        .funct  (i_funct),
        .rs     (i_rs),
        .ctrl   (dec_ctrl)
    );

    assign uses_rt = (i_opcode == OP_RTYPE) || (i_opcode == OP_SW) ||
                     (i_opcode == OP_BEQ)   || (i_opcode == OP_BNE);
    assign is_halt = (i_opcode == OP_HALT);

    assign hazard = i_valid && i_ex_mem_read && (i_ex_rt != '0) &&
                    ((i_ex_rt == i_rs) || (uses_rt && (i_ex_rt == i_rt)));

    // Flush beats a hazard so the redirected fetch is not held.
    assign o_stall = ((state_q == ST_RUN) && hazard && !i_flush) ||
                     (state_q == ST_DRAIN) || (state_q == ST_HALTED);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            id_ex_q  <= CTRL_BUBBLE;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            state_q  <= ST_RUN;
            cnt_q    <= '0;
        end else if (i_enable) begin
            case (state_q)
                ST_RUN: begin
                    if (i_valid && is_halt && !hazard && !i_flush) begin
                        state_q <= ST_DRAIN;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                ST_DRAIN: begin
                    // A flush here means the HALT was fetched down a wrong path.
                    if (i_flush) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q  <= ST_HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_HALTED: begin
                    state_q <= ST_HALTED;
                end
                default: begin
                    state_q <= ST_RUN;
                    cnt_q   <= '0;
                end
            endcase

            if (i_flush || (state_q != ST_RUN) || is_halt || hazard || !i_valid) begin
                id_ex_q <= CTRL_BUBBLE;
                valid_q <= 1'b0;
            end else begin
                id_ex_q <= dec_ctrl;
                valid_q <= 1'b1;
            end
        end
    end

    assign o_valid      = valid_q;
    assign o_alu_src    = id_ex_q.alu_src;
    assign o_ext_mode   = id_ex_q.ext_mode;
    assign o_alu_op     = id_ex_q.alu_op;
    assign o_reg_dst    = id_ex_q.reg_dst;
    assign o_reg_write  = id_ex_q.reg_write;
    assign o_mem_read   = id_ex_q.mem_read;
    assign o_mem_write  = id_ex_q.mem_write;
    assign o_mem_to_reg = id_ex_q.mem_to_reg;
    assign o_branch     = id_ex_q.branch;
    assign o_branch_ne  = id_ex_q.branch_ne;
    assign o_jump       = id_ex_q.jump;
    assign o_link       = id_ex_q.link;
    assign o_halted     = halted_q;
    assign o_state      = state_q;

endmodule

// File: tb/tb_decode_control_stage.sv
// Directed bench for decode_control_stage: decode table, hazards, flush and HALT drain.
module tb_decode_control_stage;

    logic       i_clk = 1'b0;
    logic       i_reset, i_enable, i_valid;
    logic [5:0] i_opcode, i_funct;
    logic [4:0] i_rs, i_rt, i_ex_rt;
    logic       i_ex_mem_read, i_flush;
    logic       o_stall, o_valid, o_alu_src, o_reg_dst, o_reg_write, o_mem_read;
    logic       o_mem_write, o_mem_to_reg, o_branch, o_branch_ne, o_jump, o_link, o_halted;
    logic [1:0] o_ext_mode, o_alu_op, o_state;

    int total = 0;
    int bad   = 0;

    decode_control_stage #(.DRAIN_CYCLES(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
        .i_opcode(i_opcode), .i_funct(i_funct), .i_rs(i_rs), .i_rt(i_rt),
        .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt), .i_flush(i_flush),
        .o_stall(o_stall), .o_valid(o_valid), .o_alu_src(o_alu_src),
        .o_ext_mode(o_ext_mode), .o_alu_op(o_alu_op), .o_reg_dst(o_reg_dst),
        .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_mem_to_reg(o_mem_to_reg), .o_branch(o_branch), .o_branch_ne(o_branch_ne),
        .o_jump(o_jump), .o_link(o_link), .o_halted(o_halted), .o_state(o_state)
    );

    // Clock / reset
    always #5 i_clk = ~i_clk;

    // Observed word: alu_src, ext[1:0], alu_op[1:0], reg_dst, reg_write,
    // mem_read, mem_write, mem_to_reg, branch, branch_ne, jump, link.
    logic [13:0] obs_word;
    assign obs_word = {o_alu_src, o_ext_mode, o_alu_op, o_reg_dst, o_reg_write,
                       o_mem_read, o_mem_write, o_mem_to_reg, o_branch, o_branch_ne,
                       o_jump, o_link};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Driver tasks
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt);
        i_valid = v; i_opcode = op; i_funct = fn; i_rs = rs; i_rt = rt;
        #1;
    endtask

    task automatic set_ex(input logic mr, input logic [4:0] rt);
        i_ex_mem_read = mr; i_ex_rt = rt;
        #1;
    endtask

    // Decode table: opcode, funct, rs, expected word
    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [13:0] word;
        logic        vld;
    } vec_t;

    vec_t vecs[$];

    initial begin
        vecs.push_back('{6'b000000, 6'b100000, 5'd1, 14'b0_00_10_1_1_0_0_0_0_0_0_0, 1'b1});
        vecs.push_back('{6'b001010, 6'b000000, 5'd1, 14'b1_00_01_0_1_0_0_0_0_0_0_0, 1'b1});
        vecs.push_back('{6'b001101, 6'b000000, 5'd1, 14'b1_01_11_0_1_0_0_0_0_0_0_0, 1'b1});
        vecs.push_back('{6'b001110, 6'b000000, 5'd1, 14'b1_01_11_0_1_0_0_0_0_0_0_0, 1'b1});
        vecs.push_back('{6'b001111, 6'b000000, 5'd1, 14'b1_10_00_0_1_0_0_0_0_0_0_0, 1'b1});
        vecs.push_back('{6'b100011, 6'b000000, 5'd1, 14'b1_00_00_0_1_1_0_1_0_0_0_0, 1'b1});
        vecs.push_back('{6'b101011, 6'b000000, 5'd1, 14'b1_00_00_0_0_0_1_0_0_0_0_0, 1'b1});
        vecs.push_back('{6'b000100, 6'b000000, 5'd1, 14'b0_00_01_0_0_0_0_0_1_0_0_0, 1'b1});
        vecs.push_back('{6'b000101, 6'b000000, 5'd1, 14'b0_00_01_0_0_0_0_0_0_1_0_0, 1'b1});
        vecs.push_back('{6'b000010, 6'b000000, 5'd1, 14'b0_00_00_0_0_0_0_0_0_0_1_0, 1'b1});
        vecs.push_back('{6'b000011, 6'b000000, 5'd1, 14'b0_00_00_0_1_0_0_0_0_0_1_1, 1'b1});
        vecs.push_back('{6'b010000, 6'b000000, 5'd1, 14'b0, 1'b1});
        vecs.push_back('{6'b000000, 6'b000000, 5'd0, 14'b0, 1'b1});
    end

    initial begin
        i_reset = 1'b1; i_enable = 1'b1; i_flush = 1'b0;
        set_id(1'b0, 6'd0, 6'd0, 5'd0, 5'd0);
        set_ex(1'b0, 5'd0);
        tick(); tick();
        i_reset = 1'b0;
        #1;
        check("rst_word", {18'd0, obs_word}, 32'd0);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_halted", {31'd0, o_halted}, 32'd0);
        check("rst_state", {30'd0, o_state}, 32'd0);
        check("rst_stall", {31'd0, o_stall}, 32'd0);

        // ADDI then ANDI, no hazard
        set_id(1'b1, 6'b001000, 6'd0, 5'd1, 5'd2);
        check("addi_stall", {31'd0, o_stall}, 32'd0);
        tick();
        check("addi_word", {18'd0, obs_word}, {18'd0, 14'b1_00_00_0_1_0_0_0_0_0_0_0});
        check("addi_valid", {31'd0, o_valid}, 32'd1);
        set_id(1'b1, 6'b001100, 6'd0, 5'd1, 5'd2);
        check("andi_stall", {31'd0, o_stall}, 32'd0);
        tick();
        check("andi_word", {18'd0, obs_word}, {18'd0, 14'b1_01_11_0_1_0_0_0_0_0_0_0});
        check("andi_valid", {31'd0, o_valid}, 32'd1);

        // Enable low holds the ID/EX register
        i_enable = 1'b0;
        set_id(1'b1, 6'b100011, 6'd0, 5'd1, 5'd2);
        tick();
        check("hold_word", {18'd0, obs_word}, {18'd0, 14'b1_01_11_0_1_0_0_0_0_0_0_0});
        i_enable = 1'b1;

        // Decode table
        foreach (vecs[k]) begin
            set_id(1'b1, vecs[k].op, vecs[k].fn, vecs[k].rs, 5'd2);
            tick();
            check($sformatf("dec_word_%0d", k), {18'd0, obs_word}, {18'd0, vecs[k].word});
            check($sformatf("dec_valid_%0d", k), {31'd0, o_valid}, {31'd0, vecs[k].vld});
        end

        // i_valid=0 gives a bubble
        set_id(1'b0, 6'b001000, 6'd0, 5'd1, 5'd2);
        tick();
        check("inval_valid", {31'd0, o_valid}, 32'd0);
        check("inval_word", {18'd0, obs_word}, 32'd0);

        // Load-use hazard on rs
        set_ex(1'b1, 5'd5);
        set_id(1'b1, 6'b000000, 6'b100000, 5'd5, 5'd6);
        check("haz_stall", {31'd0, o_stall}, 32'd1);
        tick();
        check("haz_valid", {31'd0, o_valid}, 32'd0);
        check("haz_word", {18'd0, obs_word}, 32'd0);
        set_ex(1'b0, 5'd0);
        check("haz_clr_stall", {31'd0, o_stall}, 32'd0);
        tick();
        check("haz_add_word", {18'd0, obs_word}, {18'd0, 14'b0_00_10_1_1_0_0_0_0_0_0_0});
        check("haz_add_valid", {31'd0, o_valid}, 32'd1);

        // Hazard through rt for R-type and SW; not for ADDI
        set_ex(1'b1, 5'd6);
        set_id(1'b1, 6'b000000, 6'b100000, 5'd1, 5'd6);
        check("haz_rt_rtype", {31'd0, o_stall}, 32'd1);
        set_id(1'b1, 6'b101011, 6'd0, 5'd1, 5'd6);
        check("haz_rt_sw", {31'd0, o_stall}, 32'd1);
        set_ex(1'b1, 5'd5);
        set_id(1'b1, 6'b001000, 6'd0, 5'd1, 5'd5);
        check("nohaz_addi_rt", {31'd0, o_stall}, 32'd0);

        // ex_rt=0 never hazards
        set_ex(1'b1, 5'd0);
        set_id(1'b1, 6'b000000, 6'b100000, 5'd0, 5'd0);
        check("nohaz_r0_stall", {31'd0, o_stall}, 32'd0);
        tick();
        check("nohaz_r0_valid", {31'd0, o_valid}, 32'd1);

        // Hazard with flush: flush wins
        set_ex(1'b1, 5'd5);
        set_id(1'b1, 6'b000000, 6'b100000, 5'd5, 5'd6);
        i_flush = 1'b1;
        #1;
        check("hzfl_stall", {31'd0, o_stall}, 32'd0);
        tick();
        check("hzfl_valid", {31'd0, o_valid}, 32'd0);
        check("hzfl_word", {18'd0, obs_word}, 32'd0);
        i_flush = 1'b0;
        set_ex(1'b0, 5'd0);

        // HALT drain, stretched by two disabled cycles
        set_id(1'b1, 6'b111111, 6'd0, 5'd0, 5'd0);
        check("halt_pre_stall", {31'd0, o_stall}, 32'd0);
        tick();
        check("halt_e0_stall", {31'd0, o_stall}, 32'd1);
        check("halt_e0_state", {30'd0, o_state}, 32'd1);
        check("halt_e0_valid", {31'd0, o_valid}, 32'd0);
        tick();
        check("halt_e1", {31'd0, o_halted}, 32'd0);
        i_enable = 1'b0;
        tick(); tick();
        check("halt_dis", {31'd0, o_halted}, 32'd0);
        check("halt_dis_stall", {31'd0, o_stall}, 32'd1);
        i_enable = 1'b1;
        tick();
        check("halt_e2", {31'd0, o_halted}, 32'd0);
        tick();
        check("halt_e3", {31'd0, o_halted}, 32'd0);
        tick();
        check("halt_e4", {31'd0, o_halted}, 32'd1);
        check("halt_e4_state", {30'd0, o_state}, 32'd2);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        #1;
        check("halted_flush_ign", {30'd0, o_state}, 32'd2);
        check("halted_stall", {31'd0, o_stall}, 32'd1);

        // Reset while HALTED
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        set_id(1'b0, 6'd0, 6'd0, 5'd0, 5'd0);
        check("rst2_halted", {31'd0, o_halted}, 32'd0);
        check("rst2_state", {30'd0, o_state}, 32'd0);
        check("rst2_word", {18'd0, obs_word}, 32'd0);
        check("rst2_stall", {31'd0, o_stall}, 32'd0);

        // HALT then flush on the second DRAIN cycle
        set_id(1'b1, 6'b111111, 6'd0, 5'd0, 5'd0);
        tick();
        tick();
        i_flush = 1'b1;
        set_id(1'b0, 6'd0, 6'd0, 5'd0, 5'd0);
        tick();
        i_flush = 1'b0;
        #1;
        check("hfl_state", {30'd0, o_state}, 32'd0);
        check("hfl_stall", {31'd0, o_stall}, 32'd0);
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("hfl_halted_%0d", c), {31'd0, o_halted}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
